// File: rtl/nn_fixed_pkg.sv
// Fixed-point constants, PLAN sigmoid segment table, saturation helper and
// FSM state encodings shared by the forward and backprop layer blocks.
package nn_fixed_pkg;

    localparam int DW_DEF   = 16;
    localparam int FRAC_DEF = 10;
    localparam int ONE_Q    = 1 << FRAC_DEF;

    // PLAN constants are stored as NUM / 2**SH so they rescale with FRAC
    localparam int PLAN_BP_HI_NUM   = 5;
    localparam int PLAN_BP_HI_SH    = 0;
    localparam int PLAN_BP_MID_NUM  = 19;
    localparam int PLAN_BP_MID_SH   = 3;
    localparam int PLAN_BP_LO_NUM   = 1;
    localparam int PLAN_BP_LO_SH    = 0;
    localparam int PLAN_OFF_HI_NUM  = 27;
    localparam int PLAN_OFF_HI_SH   = 5;
    localparam int PLAN_OFF_MID_NUM = 5;
    localparam int PLAN_OFF_MID_SH  = 3;
    localparam int PLAN_OFF_LO_NUM  = 1;
    localparam int PLAN_OFF_LO_SH   = 1;
    localparam int PLAN_SLOPE_HI_SH  = 5;
    localparam int PLAN_SLOPE_MID_SH = 3;
    localparam int PLAN_SLOPE_LO_SH  = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        ACT,
        OUT
    } state_t;

    // Clamp a signed value into the range of a w-bit two's complement number
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/sigmoid_plan.sv
// Combinational piecewise-linear (PLAN) sigmoid on a signed Q-format input;
// output is unsigned in [0, 1.0].
module sigmoid_plan
    import nn_fixed_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic signed [DW-1:0] i_z,
    output logic        [DW-1:0] o_a
);

    localparam logic [DW-1:0] ONE     = DW'((FRAC == FRAC_DEF) ? ONE_Q : (1 << FRAC));
    localparam logic [DW-1:0] BP_HI   = DW'(PLAN_BP_HI_NUM   << (FRAC - PLAN_BP_HI_SH));
    localparam logic [DW-1:0] BP_MID  = DW'(PLAN_BP_MID_NUM  << (FRAC - PLAN_BP_MID_SH));
    localparam logic [DW-1:0] BP_LO   = DW'(PLAN_BP_LO_NUM   << (FRAC - PLAN_BP_LO_SH));
    localparam logic [DW-1:0] OFF_HI  = DW'(PLAN_OFF_HI_NUM  << (FRAC - PLAN_OFF_HI_SH));
    localparam logic [DW-1:0] OFF_MID = DW'(PLAN_OFF_MID_NUM << (FRAC - PLAN_OFF_MID_SH));
    localparam logic [DW-1:0] OFF_LO  = DW'(PLAN_OFF_LO_NUM  << (FRAC - PLAN_OFF_LO_SH));
    localparam logic [DW-1:0] Z_MIN   = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] Z_MAXP  = {1'b0, {(DW-1){1'b1}}};

    logic [DW-1:0] w_mag;
    logic [DW-1:0] w_f;

    // The most negative input has no positive twin, so its magnitude is clamped
    always_comb begin
        if (!i_z[DW-1])
            w_mag = $unsigned(i_z);
        else if ($unsigned(i_z) == Z_MIN)
            w_mag = Z_MAXP;
        else
            w_mag = $unsigned(-i_z);

        if (w_mag >= BP_HI)
            w_f = ONE;
        else if (w_mag >= BP_MID)
            w_f = (w_mag >> PLAN_SLOPE_HI_SH) + OFF_HI;
        else if (w_mag >= BP_LO)
            w_f = (w_mag >> PLAN_SLOPE_MID_SH) + OFF_MID;
        else
            w_f = (w_mag >> PLAN_SLOPE_LO_SH) + OFF_LO;
    end

    assign o_a = i_z[DW-1] ? (ONE - w_f) : w_f;

endmodule

// File: rtl/forward_layer_seq.sv
// Time-multiplexed fully-connected layer: one shared MAC walks every neuron,
// with valid/ready streaming and in-place coefficient load/delta update.
module forward_layer_seq
    import nn_fixed_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int N_OUT = 3,
    parameter int DW    = DW_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int ACC_W = 40,
    localparam int AW   = $clog2(N_OUT * (N_IN + 1)),
    localparam int JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          coeff_we,
    input  logic          coeff_mode,
    input  logic [AW-1:0] coeff_addr,
    input  logic [DW-1:0] coeff_wdata,
    output logic          coeff_ready,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [DW-1:0] out_z,
    output logic [JW-1:0] out_idx,
    output logic          out_last,
    output logic          busy
);

    localparam int NCOEF = N_OUT * (N_IN + 1);
    localparam int KW    = $clog2(N_IN + 1);

    state_t                  r_state;
    logic signed [DW-1:0]    r_coef [NCOEF];
    logic signed [DW-1:0]    r_x [N_IN];
    logic [KW-1:0]           r_k;
    logic [JW-1:0]           r_j;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic [DW-1:0]           r_out_data;
    logic [DW-1:0]           r_out_z;
    logic [JW-1:0]           r_out_idx;

    int                      w_rsel;
    logic signed [DW-1:0]    w_coef;
    logic signed [DW-1:0]    w_x;
    logic signed [DW-1:0]    w_old;
    logic signed [DW-1:0]    w_new;
    logic signed [DW-1:0]    w_z;
    logic signed [2*DW-1:0]  w_prod;
    logic signed [ACC_W-1:0] w_shift;
    logic [DW-1:0]           w_a;

    // MAC step 0 reads the bias slot (i = N_IN); step k > 0 pairs w_j,(k-1) with x_(k-1)
    always_comb begin
        w_rsel = int'(r_j) * (N_IN + 1) + ((r_k == '0) ? N_IN : (int'(r_k) - 1));
        w_coef = '0;
        w_old  = '0;
        w_x    = '0;
        for (int n = 0; n < NCOEF; n++) begin
            if (n == w_rsel)
                w_coef = r_coef[n];
            if (n == int'(coeff_addr))
                w_old = r_coef[n];
        end
        for (int n = 0; n < N_IN; n++) begin
            if (n + 1 == int'(r_k))
                w_x = r_x[n];
        end
    end

    assign w_prod  = (2*DW)'(w_coef) * (2*DW)'(w_x);
    assign w_shift = r_acc >>> FRAC;
    assign w_z     = DW'(sat(64'(w_shift), DW));
    assign w_new   = coeff_mode ? DW'(sat(64'(w_old) + 64'($signed(coeff_wdata)), DW))
                                : $signed(coeff_wdata);

    sigmoid_plan #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_sigmoid (
        .i_z (w_z),
        .o_a (w_a)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_j         <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_z     <= '0;
            r_out_idx   <= '0;
            for (int n = 0; n < NCOEF; n++)
                r_coef[n] <= '0;
            for (int n = 0; n < N_IN; n++)
                r_x[n] <= '0;
        end else begin
            case (r_state)
                // Coefficient writes and the first input beat may land on the same edge
                IDLE: begin
                    if (coeff_we) begin
                        for (int n = 0; n < NCOEF; n++) begin
                            if (n == int'(coeff_addr))
                                r_coef[n] <= w_new;
                        end
                    end
                    if (in_valid) begin
                        r_x[0] <= $signed(in_data);
                        r_j    <= '0;
                        if (N_IN == 1) begin
                            r_k     <= '0;
                            r_state <= MAC;
                        end else begin
                            r_k     <= KW'(1);
                            r_state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        for (int n = 0; n < N_IN; n++) begin
                            if (n == int'(r_k))
                                r_x[n] <= $signed(in_data);
                        end
                        if (int'(r_k) == N_IN - 1) begin
                            r_k     <= '0;
                            r_state <= MAC;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                end
                MAC: begin
                    if (r_k == '0)
                        r_acc <= {{(ACC_W-DW-FRAC){w_coef[DW-1]}}, w_coef, {FRAC{1'b0}}};
                    else
                        r_acc <= r_acc + {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
                    if (int'(r_k) == N_IN)
                        r_state <= ACT;
                    else
                        r_k <= r_k + KW'(1);
                end
                ACT: begin
                    r_out_z     <= w_z;
                    r_out_data  <= w_a;
                    r_out_idx   <= r_j;
                    r_out_last  <= (int'(r_j) == N_OUT - 1);
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_k         <= '0;
                        if (r_out_last) begin
                            r_state <= IDLE;
                        end else begin
                            r_j     <= r_j + JW'(1);
                            r_state <= MAC;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign coeff_ready = (r_state == IDLE);
    assign in_ready    = (r_state == IDLE) || (r_state == LOAD);
    assign busy        = (r_state != IDLE);
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_z       = r_out_z;
    assign out_idx     = r_out_idx;
    assign out_last    = r_out_last;

endmodule

// File: tb/tb_forward_layer_seq.sv
// Directed bench for forward_layer_seq with hand-computed Q6.10 expectations
// for a 2-input, 3-neuron layer.
module tb_forward_layer_seq;

    localparam int N_IN  = 2;
    localparam int N_OUT = 3;
    localparam int DW    = 16;
    localparam int LAT   = N_IN + 2;

    logic        clk         = 1'b0;
    logic        reset_n     = 1'b0;
    logic        coeff_we    = 1'b0;
    logic        coeff_mode  = 1'b0;
    logic [3:0]  coeff_addr  = '0;
    logic [15:0] coeff_wdata = '0;
    logic        in_valid    = 1'b0;
    logic [15:0] in_data     = '0;
    logic        out_ready   = 1'b0;
    logic        coeff_ready;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [15:0] out_z;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Address map j*3+i, i=2 is the bias; every bias is -1.0
    logic [15:0] coefA [9] = '{16'd102, 16'd409, 16'hFC00,
                               16'd307, 16'd512, 16'hFC00,
                               16'd614, 16'd102, 16'hFC00};
    logic [15:0] coefSat [9] = '{default: 16'h7C00};

    forward_layer_seq #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .DW    (DW),
        .FRAC  (10),
        .ACC_W (40)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .coeff_we    (coeff_we),
        .coeff_mode  (coeff_mode),
        .coeff_addr  (coeff_addr),
        .coeff_wdata (coeff_wdata),
        .coeff_ready (coeff_ready),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_z       (out_z),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeCoef(input logic [3:0] addr, input logic [15:0] data, input logic mode);
        coeff_we    = 1'b1;
        coeff_addr  = addr;
        coeff_wdata = data;
        coeff_mode  = mode;
        tick();
        coeff_we   = 1'b0;
        coeff_mode = 1'b0;
    endtask

    task automatic loadCoefs(input logic [15:0] tbl [9]);
        for (int i = 0; i < 9; i++)
            writeCoef(4'(i), tbl[i], 1'b0);
    endtask

    task automatic sendBeat(input logic [15:0] d);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            total++;
            bad++;
            $display("[TB] FAIL in_ready_timeout: got in_ready=%b want 1 within 50 cycles", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] x0, input logic [15:0] x1);
        sendBeat(x0);
        sendBeat(x1);
    endtask

    task automatic waitOut(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        if (out_valid !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL out_valid_timeout: got out_valid=%b want 1 within 50 cycles", out_valid);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        repeat (3) @(posedge clk);
        #1;
        got = {out_valid, out_last, busy, coeff_ready, in_ready, out_idx};
        total++;
        if (got !== 7'b0001100) begin
            bad++;
            $display("[TB] FAIL reset_flags_held: got %b want %b", got, 7'b0001100);
        end
        total++;
        if ({out_data, out_z} !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_data: got data=%0d z=%0d want 0/0", out_data, out_z);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        got = {out_valid, out_last, busy, coeff_ready, in_ready, out_idx};
        total++;
        if (got !== 7'b0001100) begin
            bad++;
            $display("[TB] FAIL reset_flags_released: got %b want %b", got, 7'b0001100);
        end
    endtask

    task automatic test_forward();
        logic [15:0] ez [3] = '{16'd3064, 16'd5528, 16'd4704};
        logic [15:0] ea [3] = '{16'd959, 16'd1024, 16'd1011};
        int cyc;
        loadCoefs(coefA);
        applyStimulus(16'd8192, 16'd8192);
        for (int j = 0; j < 3; j++) begin
            waitOut(cyc);
            total++;
            if (cyc !== LAT) begin
                bad++;
                $display("[TB] FAIL fwd_latency j%0d: got %0d want %0d", j, cyc, LAT);
            end
            total++;
            if (out_z !== ez[j]) begin
                bad++;
                $display("[TB] FAIL fwd_z j%0d: got %0d want %0d", j, $signed(out_z), $signed(ez[j]));
            end
            total++;
            if (out_data !== ea[j]) begin
                bad++;
                $display("[TB] FAIL fwd_a j%0d: got %0d want %0d", j, out_data, ea[j]);
            end
            total++;
            if (out_idx !== 2'(j) || out_last !== (j == 2)) begin
                bad++;
                $display("[TB] FAIL fwd_idx_last j%0d: got idx=%0d last=%b want idx=%0d last=%b",
                         j, out_idx, out_last, j, (j == 2));
            end
            handshake();
        end
        total++;
        if (busy !== 1'b0 || coeff_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL fwd_idle_after: got busy=%b coeff_ready=%b want 0/1", busy, coeff_ready);
        end
    endtask

    task automatic test_delta();
        logic [15:0] ez [3] = '{16'd4088, 16'd5528, 16'd4704};
        logic [15:0] ea [3] = '{16'd991, 16'd1024, 16'd1011};
        logic [15:0] sz [3] = '{16'h7FFF, -16'sd717, -16'sd410};
        logic [15:0] sa [3] = '{16'd1024, 16'd333, 16'd410};
        int cyc;
        writeCoef(4'd2, 16'h0400, 1'b1);
        applyStimulus(16'd8192, 16'd8192);
        for (int j = 0; j < 3; j++) begin
            waitOut(cyc);
            total++;
            if (out_z !== ez[j] || out_data !== ea[j]) begin
                bad++;
                $display("[TB] FAIL delta_bias j%0d: got z=%0d a=%0d want z=%0d a=%0d",
                         j, $signed(out_z), out_data, $signed(ez[j]), ea[j]);
            end
            handshake();
        end
        writeCoef(4'd0, 16'h7000, 1'b0);
        writeCoef(4'd0, 16'h7C00, 1'b1);
        applyStimulus(16'd1024, 16'd0);
        for (int j = 0; j < 3; j++) begin
            waitOut(cyc);
            total++;
            if (out_z !== sz[j] || out_data !== sa[j]) begin
                bad++;
                $display("[TB] FAIL delta_sat j%0d: got z=%0d a=%0d want z=%0d a=%0d",
                         j, $signed(out_z), out_data, $signed(sz[j]), sa[j]);
            end
            handshake();
        end
    endtask

    task automatic test_saturate();
        logic [15:0] xs [2] = '{16'h7C00, 16'h8400};
        logic [15:0] ez [2] = '{16'h7FFF, 16'h8000};
        logic [15:0] ea [2] = '{16'd1024, 16'd0};
        int cyc;
        loadCoefs(coefSat);
        for (int p = 0; p < 2; p++) begin
            applyStimulus(xs[p], xs[p]);
            for (int j = 0; j < 3; j++) begin
                waitOut(cyc);
                total++;
                if (out_z !== ez[p] || out_data !== ea[p]) begin
                    bad++;
                    $display("[TB] FAIL saturate p%0d j%0d: got z=%h a=%0d want z=%h a=%0d",
                             p, j, out_z, out_data, ez[p], ea[p]);
                end
                handshake();
            end
        end
    endtask

    task automatic test_stall();
        logic [5:0] got;
        int cyc;
        loadCoefs(coefA);
        applyStimulus(16'd8192, 16'd8192);
        waitOut(cyc);
        in_valid    = 1'b1;
        in_data     = 16'h1111;
        coeff_we    = 1'b1;
        coeff_addr  = 4'd2;
        coeff_wdata = 16'h1234;
        for (int c = 0; c < 10; c++) begin
            tick();
            got = {out_valid, in_ready, coeff_ready, busy, out_idx};
            total++;
            if (got !== 6'b100100 || out_z !== 16'd3064 || out_data !== 16'd959) begin
                bad++;
                $display("[TB] FAIL stall_hold c%0d: got flags=%b z=%0d a=%0d want flags=100100 z=3064 a=959",
                         c, got, $signed(out_z), out_data);
            end
        end
        in_valid = 1'b0;
        coeff_we = 1'b0;
        handshake();
        waitOut(cyc);
        total++;
        if (cyc !== LAT || out_z !== 16'd5528 || out_last !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_release_j1: got cyc=%0d z=%0d last=%b want cyc=%0d z=5528 last=0",
                     cyc, $signed(out_z), out_last, LAT);
        end
        handshake();
        waitOut(cyc);
        total++;
        if (out_last !== 1'b1 || out_idx !== 2'd2) begin
            bad++;
            $display("[TB] FAIL stall_last_j2: got last=%b idx=%0d want last=1 idx=2", out_last, out_idx);
        end
        handshake();
        applyStimulus(16'd8192, 16'd8192);
        waitOut(cyc);
        total++;
        if (out_z !== 16'd3064 || out_data !== 16'd959) begin
            bad++;
            $display("[TB] FAIL stall_ram_unchanged: got z=%0d a=%0d want z=3064 a=959",
                     $signed(out_z), out_data);
        end
        for (int j = 0; j < 3; j++) begin
            if (j > 0)
                waitOut(cyc);
            handshake();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ez1 [3] = '{16'd3064, 16'd5528, 16'd4704};
        logic [15:0] ez2 [3] = '{16'd1020, 16'd2252, 16'd1840};
        logic [15:0] ea2 [3] = '{16'd767, 16'd921, 16'd870};
        int cyc;
        in_valid = 1'b1;
        in_data  = 16'd8192;
        tick();
        tick();
        in_data = 16'd4096;
        for (int j = 0; j < 3; j++) begin
            waitOut(cyc);
            total++;
            if (out_z !== ez1[j]) begin
                bad++;
                $display("[TB] FAIL b2b_s1 j%0d: got z=%0d want %0d", j, $signed(out_z), ez1[j]);
            end
            handshake();
        end
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_idle_gap: got in_ready=%b busy=%b want 1/0", in_ready, busy);
        end
        tick();
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_x0_taken: got busy=%b in_ready=%b want 1/1", busy, in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            waitOut(cyc);
            total++;
            if (out_z !== ez2[j] || out_data !== ea2[j]) begin
                bad++;
                $display("[TB] FAIL b2b_s2 j%0d: got z=%0d a=%0d want z=%0d a=%0d",
                         j, $signed(out_z), out_data, ez2[j], ea2[j]);
            end
            handshake();
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        applyStimulus(16'd8192, 16'd8192);
        tick();
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rst_mac: got valid=%b busy=%b in_ready=%b want 0/0/1", out_valid, busy, in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        applyStimulus(16'd8192, 16'd8192);
        for (int j = 0; j < 3; j++) begin
            waitOut(cyc);
            total++;
            if (out_z !== 16'd0 || out_data !== 16'd512) begin
                bad++;
                $display("[TB] FAIL rst_ram_zero j%0d: got z=%0d a=%0d want z=0 a=512", j, $signed(out_z), out_data);
            end
            handshake();
        end
        applyStimulus(16'd8192, 16'd8192);
        waitOut(cyc);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_z !== 16'd0 || out_data !== 16'd0) begin
            bad++;
            $display("[TB] FAIL rst_out_async: got valid=%b z=%0d a=%0d want 0/0/0", out_valid, out_z, out_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        loadCoefs(coefA);
        applyStimulus(16'd8192, 16'd8192);
        waitOut(cyc);
        total++;
        if (out_z !== 16'd3064 || out_data !== 16'd959) begin
            bad++;
            $display("[TB] FAIL rst_fresh_sample: got z=%0d a=%0d want z=3064 a=959", $signed(out_z), out_data);
        end
        for (int j = 0; j < 3; j++) begin
            if (j > 0)
                waitOut(cyc);
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_delta();
        test_saturate();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion want finish within 500000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
